// File: rtl/trace_capture_pkg.sv
// Shared types and constants for the trace change capture block.
//
// trace_evt_t is sized for the default configuration (32-bit timestamp,
// 20 probe bits). Instances built with a narrower timestamp zero-extend into
// the record and truncate on the way out, so one record type serves every
// configuration with TS_W <= TS_W_DEF and NUM_SIG <= 2**IDX_W_DEF.
package trace_capture_pkg;

    localparam int TS_W_DEF    = 32;
    localparam int NUM_SIG_DEF = 20;
    localparam int IDX_W_DEF   = $clog2(NUM_SIG_DEF);
    localparam int DROP_W      = 16;

    typedef struct packed {
        logic [TS_W_DEF-1:0]  ts;
        logic [IDX_W_DEF-1:0] idx;
        logic                 val;
    } trace_evt_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/tcc_fifo.sv
// Synchronous first-word-fall-through FIFO of trace_evt_t records.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset (empties the FIFO)
//   push       write request; ignored while full
//   push_data  record to write
//   full       no free entry (computed from registered count, no bypass)
//   pop        read request; ignored while empty
//   head       record at the head, valid whenever empty is low
//   empty      no stored record
module tcc_fifo
    import trace_capture_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  trace_evt_t push_data,
    output logic       full,
    input  logic       pop,
    output trace_evt_t head,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    trace_evt_t      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/trace_change_capture.sv
// Samples a probe vector every clock, detects bits that changed since the
// previous sample and serialises each change into a {ts, idx, val} record
// delivered through a FWFT FIFO. Changes that arrive while the scanner is
// still busy with an earlier sample are counted (once per cycle) as lost.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   en         capture enable (also gates the timestamp counter)
//   sig_i      probe vector
//   out_valid  head record present
//   out_ready  consumer accepts the head record
//   out_ts     timestamp of the head record
//   out_idx    bit index of the head record
//   out_val    new value of that bit
//   drop_cnt   saturating count of lossy cycles
//   busy       scanner active or FIFO not empty
module trace_change_capture
    import trace_capture_pkg::*;
#(
    parameter  int NUM_SIG    = 20,
    parameter  int TS_W       = 32,
    parameter  int FIFO_DEPTH = 8,
    localparam int IDX_W      = $clog2(NUM_SIG)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_SIG-1:0] sig_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TS_W-1:0]    out_ts,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_val,
    output logic [DROP_W-1:0]  drop_cnt,
    output logic               busy
);

    fsm_state_t         state_q, state_d;
    logic [NUM_SIG-1:0] prev_q;
    logic [NUM_SIG-1:0] mask_q, mask_d;
    logic [NUM_SIG-1:0] vals_q, vals_d;
    logic [TS_W-1:0]    sts_q, sts_d;
    logic [TS_W-1:0]    ts_q;
    logic               primed_q;
    logic [DROP_W-1:0]  drop_q;

    logic [NUM_SIG-1:0] chg;
    logic [NUM_SIG-1:0] mask_rest;
    logic [IDX_W-1:0]   scan_idx;
    logic               drop_inc;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    trace_evt_t         push_evt;
    trace_evt_t         head_evt;
    logic               unused_head;

    // Lowest set bit; scanning downwards lets the last hit win.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_SIG-1:0] v);
        lowest_set = '0;
        for (int i = NUM_SIG - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = IDX_W'(i);
            end
        end
    endfunction

    // Before the first enabled edge prev holds no meaningful baseline, so
    // detection waits for primed.
    assign chg       = (sig_i ^ prev_q) & {NUM_SIG{en && primed_q}};
    assign scan_idx  = lowest_set(mask_q);
    // Clearing the lowest set bit of the mask.
    assign mask_rest = mask_q & (mask_q - 1'b1);

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        vals_d    = vals_q;
        sts_d     = sts_q;
        fifo_push = 1'b0;
        drop_inc  = 1'b0;

        case (state_q)
            IDLE: begin
                if (chg != '0) begin
                    mask_d  = chg;
                    vals_d  = sig_i;
                    sts_d   = ts_q;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (!fifo_full) begin
                    fifo_push = 1'b1;
                    mask_d    = mask_rest;
                    if (mask_rest == '0) begin
                        // Final push frees the latch, so a fresh change is
                        // taken back-to-back without loss.
                        if (chg != '0) begin
                            mask_d = chg;
                            vals_d = sig_i;
                            sts_d  = ts_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (chg != '0) begin
                        drop_inc = 1'b1;
                    end
                end else if (chg != '0) begin
                    drop_inc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        push_evt                 = '0;
        push_evt.ts[TS_W-1:0]    = sts_q;
        push_evt.idx[IDX_W-1:0]  = scan_idx;
        push_evt.val             = vals_q[scan_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            ts_q     <= '0;
            primed_q <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            if (en) begin
                ts_q     <= ts_q + 1'b1;
                primed_q <= 1'b1;
            end
            if (drop_inc && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    // Sample data; meaningless until primed / latched, so no reset needed.
    always_ff @(posedge clk) begin
        prev_q <= sig_i;
        vals_q <= vals_d;
        sts_q  <= sts_d;
    end

    tcc_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_data(push_evt),
        .full     (fifo_full),
        .pop      (fifo_pop),
        .head     (head_evt),
        .empty    (fifo_empty)
    );

    // Outputs are forced to zero while rst is asserted and whenever the
    // FIFO is empty, so stale storage never reaches the port.
    assign out_valid   = !fifo_empty && !rst;
    assign fifo_pop    = out_valid && out_ready;
    assign out_ts      = out_valid ? head_evt.ts[TS_W-1:0] : '0;
    assign out_idx     = out_valid ? head_evt.idx[IDX_W-1:0] : '0;
    assign out_val     = out_valid && head_evt.val;
    assign drop_cnt    = rst ? '0 : drop_q;
    assign busy        = !rst && ((state_q != IDLE) || !fifo_empty);
    assign unused_head = ^head_evt;

endmodule

// File: tb/tb_trace_change_capture.sv
module tb_trace_change_capture;

    localparam int NS    = 20;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [NS-1:0] sig;
    logic          ready;

    // Default-width instance
    logic          valid_a;
    logic [31:0]   ts_a;
    logic [4:0]    idx_a;
    logic          val_a;
    logic [15:0]   drop_a;
    logic          busy_a;

    // 4-bit timestamp instance for wrap behaviour
    logic          valid_b;
    logic [3:0]    ts_b;
    logic [4:0]    idx_b;
    logic          val_b;
    logic [15:0]   drop_b;
    logic          busy_b;

    always #5 clk = ~clk;

    trace_change_capture dut (
        .clk(clk), .rst(rst), .en(en), .sig_i(sig),
        .out_valid(valid_a), .out_ready(ready), .out_ts(ts_a),
        .out_idx(idx_a), .out_val(val_a), .drop_cnt(drop_a), .busy(busy_a)
    );

    trace_change_capture #(.TS_W(4)) dut_w (
        .clk(clk), .rst(rst), .en(en), .sig_i(sig),
        .out_valid(valid_b), .out_ready(ready), .out_ts(ts_b),
        .out_idx(idx_b), .out_val(val_b), .drop_cnt(drop_b), .busy(busy_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, required %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A sample's changes become a list of pending records; the scanner owns
    // that list, emitting one record per cycle into an ideal FIFO queue.
    typedef struct {
        int unsigned ts;
        int          idx;
        bit          val;
    } rec_t;

    rec_t          m_fifo[$];
    rec_t          m_pend[$];
    bit [NS-1:0]   m_prev;
    bit            m_primed;
    int unsigned   m_ts;
    int            m_drop;

    task automatic model_edge();
        bit          do_pop;
        bit          was_full;
        bit          pushed;
        bit          can_take;
        bit [NS-1:0] chg;
        rec_t        r;
        if (rst) begin
            m_fifo.delete();
            m_pend.delete();
            m_primed = 0;
            m_ts     = 0;
            m_drop   = 0;
            m_prev   = sig;
            return;
        end
        do_pop   = (m_fifo.size() > 0) && ready;
        was_full = (m_fifo.size() == DEPTH);
        chg      = (en && m_primed) ? (sig ^ m_prev) : '0;
        pushed   = 0;
        can_take = 1;
        r        = '{0, 0, 0};
        if (m_pend.size() > 0) begin
            can_take = 0;
            if (!was_full) begin
                r      = m_pend.pop_front();
                pushed = 1;
                if (m_pend.size() == 0) can_take = 1;
            end
        end
        if (do_pop) void'(m_fifo.pop_front());
        if (pushed) m_fifo.push_back(r);
        if (chg != '0) begin
            if (can_take) begin
                for (int i = 0; i < NS; i++)
                    if (chg[i]) m_pend.push_back('{m_ts, i, sig[i]});
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end
        m_prev = sig;
        if (en) begin
            m_primed = 1;
            m_ts     = m_ts + 1;
        end
    endtask

    task automatic compare_all();
        bit exp_valid;
        bit exp_busy;
        exp_valid = (m_fifo.size() > 0);
        exp_busy  = (m_fifo.size() > 0) || (m_pend.size() > 0);
        check_eq("valid", valid_a, exp_valid);
        check_eq("valid_w", valid_b, exp_valid);
        check_eq("drop", drop_a, m_drop);
        check_eq("drop_w", drop_b, m_drop);
        check_eq("busy", busy_a, exp_busy);
        check_eq("busy_w", busy_b, exp_busy);
        if (exp_valid) begin
            check_eq("ts", ts_a, m_fifo[0].ts);
            check_eq("ts_w", ts_b, m_fifo[0].ts & 32'hF);
            check_eq("idx", idx_a, m_fifo[0].idx);
            check_eq("idx_w", idx_b, m_fifo[0].idx);
            check_eq("val", val_a, m_fifo[0].val);
            check_eq("val_w", val_b, m_fifo[0].val);
        end
        if (rst) begin
            check_eq("rst_ts", ts_a, 0);
            check_eq("rst_idx", idx_a, 0);
            check_eq("rst_val", val_a, 0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int guard;
        rst   = 1'b1;
        en    = 1'b0;
        sig   = '0;
        ready = 1'b1;
        m_prev = '0;

        // Reset
        run(2);
        check_eq("reset_valid", valid_a, 0);
        rst = 1'b0;
        en  = 1'b1;

        // Single toggle of bit 5 sampled while ts = 10
        guard = 0;
        while (m_ts != 10 && guard < 50) begin
            cycle();
            guard++;
        end
        check_eq("reach_ts10", m_ts, 10);
        sig[5] = 1'b1;
        cycle();
        check_eq("single_not_yet", valid_a, 0);
        cycle();
        check_eq("single_valid", valid_a, 1);
        check_eq("single_ts", ts_a, 10);
        check_eq("single_idx", idx_a, 5);
        run(4);

        // Simultaneous changes of bits 0, 3, 19
        sig = sig ^ 20'h80009;
        run(8);

        // Backpressure: all 20 bits toggle with the consumer stalled
        ready = 1'b0;
        sig   = ~sig;
        run(15);
        check_eq("bp_busy", busy_a, 1);
        check_eq("bp_full_valid", valid_a, 1);
        ready = 1'b1;
        run(30);
        check_eq("bp_drop", drop_a, 0);

        // Loss: every bit toggles every cycle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            sig = ~sig;
            cycle();
        end
        run(40);

        // Reset mid-scan with the FIFO half full
        ready = 1'b0;
        sig   = ~sig;
        run(5);
        rst = 1'b1;
        cycle();
        check_eq("midrst_valid", valid_a, 0);
        check_eq("midrst_drop", drop_a, 0);
        rst   = 1'b0;
        ready = 1'b1;
        run(5);

        // Wrap and enable gating
        run(20);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sig[2] = ~sig[2];
            cycle();
        end
        en = 1'b1;
        run(6);
        check_eq("en_gap_valid", valid_a, 0);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            en    = ($urandom_range(0, 9) != 0);
            ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 2) == 0)
                sig = sig ^ NS'($urandom() & $urandom() & $urandom());
            cycle();
        end
        rst   = 1'b0;
        ready = 1'b1;
        run(60);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/trace_change_capture.md
Name: trace_change_capture

Overview:
- Downstream consumer of a bank of per-instance probe signals, e.g. the NUM_SIG replicated `x` nets driven from the free-running `clk`.
- Samples the probe vector every clock and detects bits that changed since the previous sample.
- Serialises each change into a timestamped event record {ts, idx, val}.
- Delivers records through a buffered valid/ready stream to a trace writer. Changes the block cannot accept are counted as lost.

Parameters:
- NUM_SIG, 20, number of probe bits monitored.
- TS_W, 32, timestamp counter width.
- FIFO_DEPTH, 8, event FIFO entries; must be a power of 2 and at least 2.
- IDX_W, $clog2(NUM_SIG), derived width of the bit index; not overridable.

Ports:
- clk  input  1  single clock for the whole block.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable.
- sig_i  input  NUM_SIG  probe vector, synchronous to clk.
- out_valid  output  1  FIFO head holds a record.
- out_ready  input  1  consumer accepts the head record.
- out_ts  output  TS_W  timestamp of the head record.
- out_idx  output  IDX_W  bit index of the head record.
- out_val  output  1  new value of that bit.
- drop_cnt  output  16  count of lossy cycles; saturating.
- busy  output  1  FSM is not IDLE, or the FIFO is not empty.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `rst`.
- Outputs while rst is high, and after the reset edge:
  - out_valid = 0, busy = 0, drop_cnt = 0.
  - out_ts, out_idx, out_val = 0.
  - ts = 0, primed = 0, FSM = IDLE, FIFO empty.
- Baseline: the first clock edge after reset with en = 1 loads prev <= sig_i and sets primed. No events are produced on that edge.
- prev update: prev <= sig_i on every non-reset edge, including edges with en = 0. Re-enabling capture therefore never reports stale changes.
- Timestamp: ts increments by 1 on each edge with en = 1 and wraps modulo 2^TS_W.
  - A record carries the ts value present in the cycle its change was sampled, i.e. before that edge's increment.
- Change detection: chg = (sig_i ^ prev), gated by en && primed.
- FSM state IDLE:
  - If chg != 0: latch mask <= chg, vals <= sig_i, sts <= ts, then go to SCAN.
- FSM state SCAN, each edge:
  - If the FIFO is not full: push {sts, lowest set idx of mask, vals[idx]} and clear that mask bit.
  - If the FIFO is full: hold (stall); nothing is pushed.
- Leaving SCAN:
  - If the push empties the mask and chg != 0 on that same edge, latch the new chg/sig_i/ts and stay in SCAN. This is not a loss.
  - If the push empties the mask and chg == 0, return to IDLE.
- Loss:
  - Any edge where chg != 0 and the change cannot be latched (SCAN not on its final push, including stall cycles) increments drop_cnt by 1.
  - The increment is 1 per cycle, not per bit. drop_cnt saturates at 16'hFFFF.
- Ordering: records within one sample are emitted in ascending idx order. Samples are emitted in time order.
- Latency: a change sampled at edge N is latched at edge N. Its first record is pushed at edge N+1 when the FIFO is not full. out_valid is high in the cycle after edge N+1.
- Stream output:
  - The FIFO is first-word-fall-through; out_valid = !empty.
  - A pop occurs on an edge with out_valid && out_ready.
  - out_* stay stable while out_valid && !out_ready.
  - Push and pop in the same cycle are both allowed when full; the push succeeds only if full is computed before the pop (no bypass). The stall is therefore one extra cycle.
- en = 0 mid-SCAN: the FSM keeps draining its latched mask. No new changes are latched and none are counted as lost.
- rst mid-operation: all pending records and latched state are discarded. out_valid is 0 on the following cycle.

Decomposition:
- Package trace_capture_pkg holds:
  - the record struct trace_evt_t {ts, idx, val}, parameterised via localparams mirroring TS_W and NUM_SIG defaults;
  - the FSM state enum {IDLE, SCAN};
  - the DROP_W = 16 constant.
- Sub-module tcc_fifo: a synchronous FWFT FIFO of trace_evt_t with DEPTH, push/full, pop/empty, and synchronous active-high reset on rst.
- The lowest-set-bit priority encoder stays inline as a function.

Test Plan:
- Single toggle:
  - Stimulus: rst for 2 cycles, en = 1, hold sig_i = 0, toggle sig_i[5] 0->1 when ts = 10, out_ready = 1.
  - Response: exactly one record {ts=10, idx=5, val=1}, out_valid high 2 cycles after the sampling edge, drop_cnt = 0.
- Simultaneous changes:
  - Stimulus: bits 0, 3 and 19 toggle on one edge at ts = T.
  - Response: three records on consecutive cycles, idx 0, 3, 19, all with ts = T.
- Backpressure:
  - Stimulus: out_ready = 0, then all 20 bits toggle once.
  - Response: FIFO fills at 8 records, the FSM stalls, busy = 1. After out_ready = 1, 20 records arrive in idx order 0..19 with no loss.
- Loss counting:
  - Stimulus: all bits toggle every cycle (the clk-derived `x` pattern) for 10 cycles.
  - Response: the first sample is fully reported. drop_cnt equals the number of edges with chg != 0 that were not latched, as computed by the reference model.
- Reset mid-scan:
  - Stimulus: assert rst while the FSM is in SCAN with the FIFO half full.
  - Response: out_valid = 0 and drop_cnt = 0 next cycle. The first post-reset edge reports no events.
- Wrap / enable:
  - Stimulus: TS_W = 4 with 20 cycles of en = 1; then en = 0 for 3 cycles while bit 2 toggles, followed by en = 1.
  - Response: ts wraps 15 -> 0. No record is produced for the toggle of bit 2 made while en = 0.
